// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM-backed stream FIFO and its output buffer.
package sram_fifo_pkg;

  localparam int SRAM_DW    = 32;
  localparam int SRAM_AW    = 7;
  localparam int SRAM_DEPTH = 1 << SRAM_AW;
  localparam int OBUF_DEPTH = 2;
  localparam int RD_LAT     = 1;

  typedef logic [1:0] ob_cnt_t;

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry registered output buffer; slot0 is always the head, so head data is a flop output.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DW = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output ob_cnt_t       cnt,
  output logic [DW-1:0] head
);

  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;

  // NOTE: sequential state is assigned with <= only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ob_cnt_t'(push) - ob_cnt_t'(pop);
    end
  end

  // NOTE: payload slots have no reset; cnt alone says which slots hold live data.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (cnt == 2'd2) slot0 <= slot1;
      if (push) begin
        if (cnt == 2'd1) slot0 <= din;
        else             slot1 <= din;
      end
    end else if (push) begin
      if (cnt == 2'd0) slot0 <= din;
      else             slot1 <= din;
    end
  end

  assign head = slot0;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n || flush)
    !(push && !pop && cnt == ob_cnt_t'(OBUF_DEPTH)))
    else $error("sram_fifo_obuf: push into full buffer");

endmodule

// File: rtl/sram_stream_fifo.sv
// Stream FIFO controller wrapped around a 1R1W SRAM macro with a 1-cycle read latency.
module sram_stream_fifo
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DW,
  parameter int ADDR_WIDTH = SRAM_AW,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int LVL_W      = $clog2(DEPTH + 2) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LVL_W-1:0]      level,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      sram_cnt;
  logic                  rd_inflight;
  ob_cnt_t               ob_cnt;
  ob_cnt_t               pend;
  logic                  clr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  pop;

  assign clr = !rst_n || flush;

  assign in_ready = (sram_cnt != CNT_W'(DEPTH)) && !clr;
  assign wr_fire  = in_valid && in_ready;

  assign sram_csb0  = ~wr_fire;
  assign sram_addr0 = wr_ptr;
  assign sram_din0  = in_data;

  // Reads already committed to the buffer (held or in flight) must leave room for this one,
  // unless the head pops in the same cycle.
  assign pend    = ob_cnt + ob_cnt_t'(rd_inflight);
  assign pop     = out_valid && out_ready;
  assign rd_fire = (sram_cnt != '0) && !clr &&
                   ((pend < ob_cnt_t'(OBUF_DEPTH)) ||
                    ((pend == ob_cnt_t'(OBUF_DEPTH)) && pop));

  assign sram_csb1  = ~rd_fire;
  assign sram_addr1 = rd_ptr;

  // sram_cnt only counts writes issued on earlier edges, so rd_ptr never chases a same-cycle write.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      sram_cnt    <= sram_cnt + CNT_W'(wr_fire) - CNT_W'(rd_fire);
      rd_inflight <= rd_fire;
    end
  end

  // A capture arriving in the flush cycle is dropped by the buffer's own clear.
  sram_fifo_obuf #(
    .DW (DATA_WIDTH)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (rd_inflight),
    .pop   (pop),
    .din   (sram_dout1),
    .cnt   (ob_cnt),
    .head  (out_data)
  );

  assign out_valid = (ob_cnt != '0);
  assign level     = LVL_W'(sram_cnt) + LVL_W'(rd_inflight) + LVL_W'(ob_cnt);

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Directed bench for sram_stream_fifo with a behavioural 32x128 1R1W macro and a reference queue.
module tb_sram_stream_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [8:0]  level;
  logic        sram_csb0;
  logic [6:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic        sram_csb1;
  logic [6:0]  sram_addr1;
  logic [31:0] sram_dout1;

  int compared   = 0;
  int mismatched = 0;
  int n_pop      = 0;

  logic [31:0] model_q[$];

  always #5 clk = ~clk;

  sram_stream_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  // Macro model: ports sampled at posedge, write commits at negedge, read data valid for one cycle.
  logic [31:0] mem [128];
  logic        wr_q;
  logic [6:0]  waddr_q;
  logic [31:0] wdata_q;

  always @(posedge clk) begin
    if (sram_csb0 === 1'b0 && sram_csb1 === 1'b0) begin
      compared++;
      if (sram_addr0 === sram_addr1) begin
        mismatched++;
        $display("FAIL same_addr_access addr0=%0d addr1=%0d must differ", sram_addr0, sram_addr1);
      end
    end
    wr_q       <= (sram_csb0 === 1'b0);
    waddr_q    <= sram_addr0;
    wdata_q    <= sram_din0;
    sram_dout1 <= (sram_csb1 === 1'b0) ? mem[sram_addr1] : 'x;
  end

  always @(negedge clk) begin
    if (wr_q) mem[waddr_q] <= wdata_q;
  end

  // Scoreboard: order of popped words and level against the reference occupancy.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      model_q.delete();
    end else begin
      compared++;
      if (level !== 9'(model_q.size())) begin
        mismatched++;
        $display("FAIL level got %0d want %0d", level, model_q.size());
      end
      if (out_valid === 1'b1 && out_ready) begin
        compared++;
        if (model_q.size() == 0) begin
          mismatched++;
          $display("FAIL pop_empty got %h want no pop", out_data);
        end else if (out_data !== model_q[0]) begin
          mismatched++;
          $display("FAIL pop_data got %h want %h", out_data, model_q[0]);
        end
        if (model_q.size() != 0) void'(model_q.pop_front());
        n_pop++;
      end
      if (in_valid && in_ready === 1'b1) model_q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Streams n words base..base+n-1; cycle index 0 is the first cycle of driving.
  task automatic run_stream(input int n, input logic [31:0] base, input int vpct, input int rpct,
                            input int budget, output int cycles, output int stalls,
                            output int first_vld, output logic [31:0] first_data);
    int sent;
    int p0;
    sent = 0;
    p0 = n_pop;
    cycles = 0;
    stalls = 0;
    first_vld = -1;
    first_data = 'x;
    while ((n_pop - p0) < n && cycles < budget) begin
      tick();
      in_valid  = (sent < n) && ($urandom_range(99) < vpct);
      in_data   = base + sent;
      out_ready = ($urandom_range(99) < rpct);
      settle();
      if (out_valid === 1'b1 && first_vld < 0) begin
        first_vld = cycles;
        first_data = out_data;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      else if (in_valid) stalls++;
      cycles++;
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    compared++;
    if ((n_pop - p0) != n) begin
      mismatched++;
      $display("FAIL stream_timeout got %0d pops want %0d", n_pop - p0, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h1234_5678;
    out_ready = 1'b1;
    repeat (2) tick();
    settle();
    compared++;
    if (sram_csb0 !== 1'b1) begin mismatched++; $display("FAIL reset_csb0 got %b want 1", sram_csb0); end
    compared++;
    if (sram_csb1 !== 1'b1) begin mismatched++; $display("FAIL reset_csb1 got %b want 1", sram_csb1); end
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    compared++;
    if (level !== 9'd0) begin mismatched++; $display("FAIL reset_level got %0d want 0", level); end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    settle();
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int cyc, st, fv;
    logic [31:0] fd;
    run_stream(5, 32'h0000_0001, 100, 100, 100, cyc, st, fv, fd);
    // Accept seen in cycle 0 (edge N); out_valid first seen after edge N+2, i.e. cycle 3.
    compared++;
    if (fv !== 3) begin mismatched++; $display("FAIL basic_latency got %0d want 3", fv); end
    compared++;
    if (fd !== 32'h0000_0001) begin mismatched++; $display("FAIL basic_first got %h want 00000001", fd); end
    compared++;
    if (cyc !== 8) begin mismatched++; $display("FAIL basic_cycles got %0d want 8", cyc); end
    settle();
    compared++;
    if (level !== 9'd0) begin mismatched++; $display("FAIL basic_level got %0d want 0", level); end
  endtask

  task automatic test_fill();
    int acc;
    int bad_csb;
    int p0;
    acc = 0;
    bad_csb = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      in_valid = 1'b1;
      in_data = 32'hA000_0000 + acc;
      settle();
      if (in_ready !== 1'b1) break;
      acc++;
    end
    compared++;
    if (acc !== 130) begin mismatched++; $display("FAIL fill_accepts got %0d want 130", acc); end
    compared++;
    if (level !== 9'd130) begin mismatched++; $display("FAIL fill_level got %0d want 130", level); end
    for (int c = 0; c < 5; c++) begin
      tick();
      settle();
      if (sram_csb0 !== 1'b1 || in_ready !== 1'b0) bad_csb++;
    end
    compared++;
    if (bad_csb !== 0) begin mismatched++; $display("FAIL fill_hold got %0d bad cycles want 0", bad_csb); end
    p0 = n_pop;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      settle();
      if (model_q.size() == 0 && level == 9'd0) break;
      tick();
    end
    out_ready = 1'b0;
    compared++;
    if ((n_pop - p0) !== 130) begin mismatched++; $display("FAIL fill_drain got %0d want 130", n_pop - p0); end
  endtask

  task automatic test_back_to_back();
    int cyc, st, fv;
    logic [31:0] fd;
    run_stream(300, 32'hB000_0000, 100, 100, 1000, cyc, st, fv, fd);
    // One word per cycle: 300 accepts plus 3 cycles of pipeline latency.
    compared++;
    if (cyc !== 303) begin mismatched++; $display("FAIL b2b_cycles got %0d want 303", cyc); end
    compared++;
    if (st !== 0) begin mismatched++; $display("FAIL b2b_stalls got %0d want 0", st); end
  endtask

  task automatic test_random();
    int cyc, st, fv;
    logic [31:0] fd;
    run_stream(2000, 32'h5000_0000, 50, 50, 30000, cyc, st, fv, fd);
    settle();
    compared++;
    if (level !== 9'd0) begin mismatched++; $display("FAIL random_level got %0d want 0", level); end
  endtask

  task automatic test_flush();
    int acc;
    int cyc, st, fv;
    logic [31:0] fd;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 40 && acc < 10; c++) begin
      tick();
      in_valid = 1'b1;
      in_data = 32'h0000_0100 + acc;
      settle();
      if (in_ready === 1'b1) acc++;
    end
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    settle();
    compared++;
    if (level !== 9'd10) begin mismatched++; $display("FAIL flush_prefill got %0d want 10", level); end
    // Buffer full and popping: a read issues this cycle and is in flight during the flush.
    tick();
    out_ready = 1'b1;
    settle();
    compared++;
    if (sram_csb1 !== 1'b0) begin mismatched++; $display("FAIL flush_rd_issue got %b want 0", sram_csb1); end
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h5555_5555;
    settle();
    compared++;
    if (level !== 9'd9) begin mismatched++; $display("FAIL flush_inflight_level got %0d want 9", level); end
    compared++;
    if (in_ready !== 1'b0 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_ports got ready=%b csb0=%b csb1=%b want 0 1 1", in_ready, sram_csb0, sram_csb1);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    settle();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    compared++;
    if (level !== 9'd0) begin mismatched++; $display("FAIL flush_level got %0d want 0", level); end
    run_stream(1, 32'hDEAD_BEEF, 100, 100, 50, cyc, st, fv, fd);
    compared++;
    if (fd !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL flush_first got %h want deadbeef", fd); end
  endtask

  task automatic test_reset_mid();
    int acc;
    int cyc, st, fv;
    logic [31:0] fd;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      in_valid = 1'b1;
      out_ready = (c % 3) != 0;
      in_data = 32'h0000_7700 + acc;
      settle();
      if (in_ready === 1'b1) acc++;
    end
    tick();
    rst_n = 1'b0;
    settle();
    compared++;
    if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_ports got csb0=%b csb1=%b ready=%b want 1 1 0", sram_csb0, sram_csb1, in_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      compared++;
      if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL rstmid_hold got csb0=%b csb1=%b ready=%b valid=%b want 1 1 0 0",
                 sram_csb0, sram_csb1, in_ready, out_valid);
      end
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    run_stream(20, 32'h3300_0000, 100, 100, 200, cyc, st, fv, fd);
    compared++;
    if (fd !== 32'h3300_0000 || cyc !== 23) begin
      mismatched++;
      $display("FAIL rstmid_resume got first=%h cycles=%0d want 33000000 23", fd, cyc);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_stream_fifo.md
Name: sram_stream_fifo

Overview:
- Stream FIFO controller that sits directly in front of and behind the 32x128 1R1W SRAM macro.
- Upstream side: accepts a valid/ready stream and drives the macro write port (csb0/addr0/din0).
- Downstream side: drives the macro read port (csb1/addr1), captures dout1 one cycle later into a 2-entry output buffer, and presents a valid/ready stream.
- Used as the elastic buffer between producer and consumer stages in the accelerator datapath.

Parameters:
- DATA_WIDTH, 32, word width; must equal the macro word size.
- ADDR_WIDTH, 7, macro address width.
- DEPTH, 1<<ADDR_WIDTH, SRAM entries (128).
- LVL_W, $clog2(DEPTH+2)+1, width of the occupancy output.

Ports:
- clk  in  1  single clock; drives macro clk0 and clk1.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of all contents.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept.
- in_data  in  DATA_WIDTH  write data.
- out_valid  out  1  head data available.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH  head data.
- level  out  LVL_W  total occupancy (SRAM + in-flight + output buffer).
- sram_csb0  out  1  macro write chip select, active low.
- sram_addr0  out  ADDR_WIDTH  macro write address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_csb1  out  1  macro read chip select, active low.
- sram_addr1  out  ADDR_WIDTH  macro read address.
- sram_dout1  in  DATA_WIDTH  macro read data; valid only at the posedge after a read issue, X otherwise.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Macro timing contract:
  - Inputs are sampled at posedge; the write commits at the following negedge.
  - Read data must be captured exactly at the next posedge (1-cycle latency); it is X thereafter.
- State registers: wr_ptr[ADDR_WIDTH-1:0], rd_ptr[ADDR_WIDTH-1:0], sram_cnt (0..DEPTH), rd_inflight (1 bit), ob_cnt (0..2).
- Write path:
  - in_ready = (sram_cnt != DEPTH) && !flush.
  - wr_fire = in_valid & in_ready.
  - sram_csb0 = ~wr_fire; sram_addr0 = wr_ptr; sram_din0 = in_data. These are combinational; the macro registers them.
  - On wr_fire, wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read issue:
  - rd_fire = (sram_cnt != 0) && !flush && ((ob_cnt + rd_inflight) < 2 || ((ob_cnt + rd_inflight) == 2 && out_valid && out_ready)).
  - sram_csb1 = ~rd_fire; sram_addr1 = rd_ptr.
  - On rd_fire, rd_ptr increments (with wrap) and rd_inflight <= 1; otherwise rd_inflight <= 0.
- Counter update: sram_cnt <= sram_cnt + wr_fire - rd_fire. A simultaneous write and read leaves it unchanged.
- Write/read ordering:
  - sram_cnt counts only entries whose write was issued in a prior cycle, so the read address never equals the same-cycle write address.
  - The macro simultaneous-access warning must never fire.
- Capture:
  - If rd_inflight, sram_dout1 is pushed into the output buffer at that posedge.
  - The buffer is FIFO-ordered; pop on out_valid & out_ready; push and pop in the same cycle are both allowed.
  - The issue rule guarantees the buffer never overflows. Assert: push with ob_cnt==2 and no pop is an error.
- Output: out_valid = (ob_cnt != 0); out_data = buffer head (registered, never X when out_valid=1).
- Throughput and latency:
  - Steady state sustains 1 word/cycle in and out.
  - Minimum latency is 2 cycles: in_data accepted at edge N, read issued in cycle N+1, out_valid=1 after edge N+2.
- Capacity and level:
  - Total capacity is DEPTH+2 = 130. in_ready depends only on sram_cnt, so up to 130 words are held with the consumer stalled.
  - level = sram_cnt + rd_inflight + ob_cnt, registered-consistent and combinational from state.
- Reset and flush (identical effect):
  - Pointers, sram_cnt, rd_inflight and ob_cnt go to 0.
  - Outputs: out_valid=0, in_ready=0 during flush/reset, level=0, sram_csb0=1, sram_csb1=1.
  - The capture of an in-flight read in the flush cycle is discarded.
  - SRAM contents are not cleared.
- Reset mid-operation: all data is lost; no macro access is issued while rst_n=0.

Decomposition:
- Package sram_fifo_pkg: SRAM_DW=32, SRAM_AW=7, SRAM_DEPTH=128, OBUF_DEPTH=2, read-latency constant RD_LAT=1.
- One sub-module: sram_fifo_obuf, a 2-entry registered output buffer with push/pop, count, head data and flush.

Test Plan:
- Reset, then write 0x00000001..0x00000005 with out_ready=1: out_data sequence 1..5; first out_valid 2 cycles after first accept; level returns to 0.
- out_ready=0, stream 0xA0000000+i continuously: in_ready drops after 130 accepts, level=130, sram_csb0 stays 1 afterwards; release out_ready: all 130 words drain in order.
- Continuous in_valid and out_ready for 300 words: 1 word/cycle after fill, pointers wrap past 127, no data loss, no simultaneous same-address access warning.
- Random valid/ready at 50% each for 2000 words against a reference queue: exact order match, level always equals the model count.
- Fill 10 words, assert flush for 1 cycle during an in-flight read: next cycle out_valid=0, level=0; new word 0xDEADBEEF emerges first.
- Assert rst_n=0 mid-stream with in_valid=1: sram_csb0=sram_csb1=1, in_ready=0, out_valid=0 while low; normal operation resumes cleanly after release.
